// File: rtl/uart_tx_queue.sv
// Byte FIFO between the core and the RAM/HCI bus. Writes to the UART port are queued
// and drained to the transmitter. The core stalls only on a full FIFO, or on I/O reads
// and stop writes that must wait for the FIFO to drain.
module uart_tx_queue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic [31:0]           cpu_a,
  input  logic [7:0]            cpu_dout,
  input  logic                  cpu_wr,
  output logic                  cpu_rdy,
  output logic [31:0]           bus_a,
  output logic [7:0]            bus_dout,
  output logic                  bus_wr,
  input  logic                  io_buffer_full,
  output logic [7:0]            tx_data,
  output logic                  tx_wr,
  output logic                  halt,
  output logic [DEPTH_LOG2:0]   fifo_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [PW-1:0] head, tail, head_next, tail_next;
  logic [7:0]    mem [DEPTH];

  logic io, tx_hit, stop_hit, io_rd;
  logic empty, full, stall;
  logic do_enq, do_deq;

  always_comb begin
    io       = (cpu_a[17:16] == 2'b11);
    tx_hit   = io & cpu_wr & (cpu_a[2:0] == 3'd0);
    stop_hit = io & cpu_wr & (cpu_a[2:0] == 3'd4);
    io_rd    = io & ~cpu_wr;
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  always_comb begin
    empty = (head == tail);
    full  = (head[PW-2:0] == tail[PW-2:0]) && (head[PW-1] != tail[PW-1]);
    stall = (tx_hit & full) | ((stop_hit | io_rd) & ~empty);
  end

  always_comb begin
    cpu_rdy  = rdy_in & ~stall;
    bus_a    = cpu_a;
    bus_dout = cpu_dout;
    bus_wr   = cpu_wr & ~tx_hit & ~(stop_hit & stall);
  end

  // Zero bytes are accepted without being queued; after halt nothing is queued.
  always_comb begin
    do_enq    = rdy_in & tx_hit & ~full & (cpu_dout != 8'h00) & ~halt;
    do_deq    = rdy_in & ~empty & ~io_buffer_full;
    tail_next = tail + PW'(do_enq);
    head_next = head + PW'(do_deq);
  end

  always_ff @(posedge clk_in) begin
    if (do_enq) mem[tail[PW-2:0]] <= cpu_dout;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      head       <= '0;
      tail       <= '0;
      fifo_count <= '0;
      tx_data    <= 8'h00;
      tx_wr      <= 1'b0;
      halt       <= 1'b0;
    end else begin
      head       <= head_next;
      tail       <= tail_next;
      fifo_count <= tail_next - head_next;
      tx_wr      <= do_deq;
      if (do_deq) tx_data <= mem[head[PW-2:0]];
      if (rdy_in & stop_hit & ~stall) halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: directed scenarios plus random traffic,
// compared cycle by cycle against a byte-queue reference model.
module tb_uart_tx_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic        cpu_rdy;
  logic [31:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_wr;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        halt;
  logic [4:0]  fifo_count;

  uart_tx_queue #(.DEPTH_LOG2(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wr(cpu_wr), .cpu_rdy(cpu_rdy),
    .bus_a(bus_a), .bus_dout(bus_dout), .bus_wr(bus_wr),
    .io_buffer_full(io_buffer_full), .tx_data(tx_data), .tx_wr(tx_wr),
    .halt(halt), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // stimulus values applied at the next step
  logic [31:0] a_v   = 32'h0000_0010;
  logic [7:0]  d_v   = 8'h00;
  logic        wr_v  = 1'b0;
  logic        ibf_v = 1'b0;
  logic        rdy_v = 1'b1;

  // reference model
  logic [7:0]  mq[$];
  logic        m_halt    = 1'b0;
  logic        m_tx_wr   = 1'b0;
  logic [7:0]  m_tx_data = 8'h00;
  logic        last_rdy  = 1'b0;
  logic [7:0]  sent[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    logic io, txh, stph, iord, mfull, mempty, mstall, enq, deq;
    @(negedge clk);
    cpu_a = a_v; cpu_dout = d_v; cpu_wr = wr_v;
    io_buffer_full = ibf_v; rdy_in = rdy_v;
    #1;
    io     = (a_v[17:16] == 2'b11);
    txh    = io && wr_v && (a_v[2:0] == 3'd0);
    stph   = io && wr_v && (a_v[2:0] == 3'd4);
    iord   = io && !wr_v;
    mfull  = (mq.size() == 16);
    mempty = (mq.size() == 0);
    mstall = (txh && mfull) || ((stph || iord) && !mempty);
    last_rdy = rdy_v && !mstall;
    chk("cpu_rdy", {31'd0, cpu_rdy}, {31'd0, last_rdy});
    chk("bus_wr", {31'd0, bus_wr}, {31'd0, wr_v && !txh && !(stph && mstall)});
    chk("bus_a", bus_a, a_v);
    chk("bus_dout", {24'd0, bus_dout}, {24'd0, d_v});
    @(posedge clk);
    enq = rdy_v && txh && !mfull && (d_v != 8'h00) && !m_halt;
    deq = rdy_v && !mempty && !ibf_v;
    m_tx_wr = deq;
    if (deq) m_tx_data = mq.pop_front();
    if (enq) mq.push_back(d_v);
    if (rdy_v && stph && !mstall) m_halt = 1'b1;
    #1;
    chk("tx_wr", {31'd0, tx_wr}, {31'd0, m_tx_wr});
    chk("tx_data", {24'd0, tx_data}, {24'd0, m_tx_data});
    chk("fifo_count", {27'd0, fifo_count}, mq.size());
    chk("halt", {31'd0, halt}, {31'd0, m_halt});
    if (tx_wr) sent.push_back(tx_data);
  endtask

  task automatic idle(input int n);
    a_v = 32'h0000_0010; wr_v = 1'b0; d_v = 8'h00;
    for (int i = 0; i < n; i++) step();
  endtask

  // hold a core access until the model says the core was not stalled
  task automatic access(input logic [31:0] a, input logic [7:0] d, input logic wr);
    a_v = a; d_v = d; wr_v = wr;
    for (int i = 0; i < 64; i++) begin
      step();
      if (last_rdy) return;
    end
    chk("access_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    m_halt = 1'b0; m_tx_wr = 1'b0; m_tx_data = 8'h00;
    chk("rst_tx_wr", {31'd0, tx_wr}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
    chk("rst_count", {27'd0, fifo_count}, 32'd0);
    chk("rst_halt", {31'd0, halt}, 32'd0);
    chk("rst_cpu_rdy", {31'd0, cpu_rdy}, {31'd0, rdy_in});
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rdy_in = 1'b1; cpu_a = 32'h10; cpu_dout = 8'h00;
    cpu_wr = 1'b0; io_buffer_full = 1'b0;
    #12;
    do_reset();

    // two consecutive UART writes, drained immediately
    ibf_v = 1'b0;
    sent.delete();
    access(32'h0003_0000, 8'h48, 1'b1);
    access(32'h0003_0000, 8'h69, 1'b1);
    idle(4);
    chk("hi_count", sent.size(), 32'd2);
    if (sent.size() == 2) begin
      chk("hi_b0", {24'd0, sent[0]}, 32'h48);
      chk("hi_b1", {24'd0, sent[1]}, 32'h69);
    end

    // fill to 16, 17th stalls until a slot frees
    ibf_v = 1'b1;
    sent.delete();
    for (int i = 0; i < 16; i++) access(32'h0003_0000, 8'h41 + 8'(i), 1'b1);
    chk("count16", {27'd0, fifo_count}, 32'd16);
    a_v = 32'h0003_0000; d_v = 8'h51; wr_v = 1'b1;
    step();
    chk("stall17", {31'd0, cpu_rdy}, 32'd0);
    ibf_v = 1'b0;
    access(32'h0003_0000, 8'h51, 1'b1);
    idle(20);
    chk("fill_sent", sent.size(), 32'd17);
    for (int i = 0; i < 17 && i < sent.size(); i++)
      chk("fill_order", {24'd0, sent[i]}, 32'h41 + i);

    // zero byte is dropped
    access(32'h0003_0000, 8'h00, 1'b1);
    idle(2);
    chk("zero_count", {27'd0, fifo_count}, 32'd0);

    // I/O read waits for drain; RAM read does not
    ibf_v = 1'b1;
    access(32'h0003_0000, 8'h11, 1'b1);
    access(32'h0003_0000, 8'h22, 1'b1);
    a_v = 32'h0000_0010; wr_v = 1'b0;
    step();
    chk("ram_rd_rdy", {31'd0, cpu_rdy}, 32'd1);
    a_v = 32'h0003_0000;
    step(); step();
    chk("io_rd_stall", {31'd0, cpu_rdy}, 32'd0);
    ibf_v = 1'b0;
    access(32'h0003_0000, 8'h00, 1'b0);
    idle(2);

    // rdy_in low freezes everything
    ibf_v = 1'b1;
    access(32'h0003_0000, 8'h33, 1'b1);
    access(32'h0003_0000, 8'h34, 1'b1);
    ibf_v = 1'b0; rdy_v = 1'b0;
    a_v = 32'h0003_0000; d_v = 8'h35; wr_v = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("frozen_count", {27'd0, fifo_count}, 32'd2);
    rdy_v = 1'b1;
    idle(4);

    // reset mid-drain with 5 bytes queued
    ibf_v = 1'b1;
    for (int i = 0; i < 5; i++) access(32'h0003_0000, 8'h60 + 8'(i), 1'b1);
    ibf_v = 1'b0;
    idle(1);
    do_reset();
    sent.delete();
    idle(4);
    chk("post_rst_tx", sent.size(), 32'd0);

    // program stop waits for the FIFO to drain, then halts
    ibf_v = 1'b1;
    for (int i = 0; i < 3; i++) access(32'h0003_0000, 8'h70 + 8'(i), 1'b1);
    a_v = 32'h0003_0004; d_v = 8'h01; wr_v = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("stop_stall", {31'd0, cpu_rdy}, 32'd0);
    chk("stop_no_bus", {31'd0, bus_wr}, 32'd0);
    ibf_v = 1'b0;
    access(32'h0003_0004, 8'h01, 1'b1);
    chk("halt_set", {31'd0, halt}, 32'd1);
    access(32'h0003_0000, 8'h55, 1'b1);
    idle(2);
    chk("halt_drop", {27'd0, fifo_count}, 32'd0);
    chk("halt_held", {31'd0, halt}, 32'd1);
    do_reset();

    // random traffic
    for (int n = 0; n < 2500; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: a_v = 32'h0003_0000;
        4:          a_v = ($urandom_range(0, 30) == 0) ? 32'h0003_0004 : 32'h0003_0008;
        5:          a_v = 32'h0003_0000 | 32'($urandom_range(1, 7));
        default:    a_v = $urandom & 32'h0002_FFFF;
      endcase
      wr_v  = ($urandom_range(0, 3) != 0);
      d_v   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      ibf_v = ($urandom_range(0, 2) == 0);
      rdy_v = ($urandom_range(0, 9) != 0);
      step();
      if ((m_halt && $urandom_range(0, 15) == 0) || $urandom_range(0, 400) == 0)
        do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
